// File: rtl/reg_file_if.sv
// Register-file access bundle: two combinational read ports, one write port and ready.
// The core side uses the master modport; reg_file uses the slave modport.
interface reg_file_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1_a;
    logic [ADDR_W-1:0] rs2_a;
    logic [XLEN-1:0]   rs1_d;
    logic [XLEN-1:0]   rs2_d;
    logic [ADDR_W-1:0] rd_a;
    logic [XLEN-1:0]   rd_d;
    logic              rd_we;
    logic              ready;

    modport master (
        output rs1_a, rs2_a, rd_a, rd_d, rd_we,
        input  rs1_d, rs2_d, ready
    );

    modport slave (
        input  rs1_a, rs2_a, rd_a, rd_d, rd_we,
        output rs1_d, rs2_d, ready
    );
endinterface

// File: rtl/reg_file.sv
// Integer register file: 2 async read ports, 1 sync write port, post-reset clear of x1..x(NREG-1).
// Optional macro REG_FILE_BYPASS_EN enables same-cycle write-through to the read ports.
module reg_file #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    localparam logic [0:0]        ST_CLEAR  = 1'b0;
    localparam logic [0:0]        ST_RUN    = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

    logic [0:0]        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              ready_reg, ready_next;

    logic [XLEN-1:0]   mem [NREG];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;

    // The clear shares the single write port; user writes only reach it in RUN.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready_next = ready_reg;
        wr_en      = 1'b0;
        wr_addr    = bus.rd_a;
        wr_data    = bus.rd_d;
        case (state_reg)
            ST_CLEAR: begin
                wr_en    = 1'b1;
                wr_addr  = cnt_reg;
                wr_data  = '0;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                    ready_next = 1'b1;
                end
            end
            default: begin
                wr_en = bus.rd_we;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= ADDR_W'(1);
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
        end
    end

    // x0 is never stored; its reads are tied to zero below.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    logic [XLEN-1:0] rd_port_d [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic [ADDR_W-1:0] addr;
            logic [XLEN-1:0]   data;

            assign addr = (gi == 0) ? bus.rs1_a : bus.rs2_a;

            always_comb begin
                data = '0;
                if ((state_reg == ST_RUN) && (addr != '0)) begin
                    data = mem[addr];
`ifdef REG_FILE_BYPASS_EN
                    if (bus.rd_we && (bus.rd_a == addr)) begin
                        data = bus.rd_d;
                    end
`endif
                end
            end

            assign rd_port_d[gi] = data;
        end
    endgenerate

    assign bus.rs1_d = rd_port_d[0];
    assign bus.rs2_d = rd_port_d[1];
    assign bus.ready = ready_reg;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps plus randomized traffic against an array model.
module tb_reg_file;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic clk;
    logic rst;

    reg_file_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    reg_file #(.XLEN(XLEN), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] model_mem [NREG];
    bit              model_ready;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value a read port should show given the current drive on the write port.
    function automatic logic [XLEN-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (!model_ready || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (bus.rd_we && bus.rd_a != 0 && bus.rd_a == a) return bus.rd_d;
`endif
        return model_mem[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, check both ports before the edge, clock, update the model.
    task automatic cycle(input logic we, input logic [ADDR_W-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2, input bit check);
        bus.rd_we = we;
        bus.rd_a  = wa;
        bus.rd_d  = wd;
        bus.rs1_a = a1;
        bus.rs2_a = a2;
        #1;
        if (check) begin
            chk($sformatf("rs1 x%0d", a1), bus.rs1_d, exp_read(a1));
            chk($sformatf("rs2 x%0d", a2), bus.rs2_d, exp_read(a2));
        end
        tick();
        if (model_ready && we && wa != 0) model_mem[wa] = wd;
        bus.rd_we = 1'b0;
    endtask

    // Walk the 31-edge clear after rst release; writes attempted on edges 5..10 must vanish.
    task automatic run_clear();
        for (int k = 1; k <= NREG - 1; k++) begin
            bus.rs1_a = 5;
            bus.rs2_a = 31;
            bus.rd_we = (k >= 5 && k <= 10);
            bus.rd_a  = 3;
            bus.rd_d  = 32'h1234_5678;
            #1;
            chk($sformatf("clear ready before edge %0d", k), {31'b0, bus.ready}, 32'd0);
            if (k == 1 || k == 30) begin
                chk("clear rs1 forced 0", bus.rs1_d, 32'd0);
                chk("clear rs2 forced 0", bus.rs2_d, 32'd0);
            end
            tick();
        end
        bus.rd_we = 1'b0;
        for (int i = 1; i < NREG; i++) model_mem[i] = '0;
        model_ready = 1'b1;
        chk("ready after edge 31", {31'b0, bus.ready}, 32'd1);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b0;
        model_ready = 1'b0;
        #1;
        chk("ready low in reset", {31'b0, bus.ready}, 32'd0);
        chk("rs1 zero in reset", bus.rs1_d, 32'd0);
        repeat (cycles) tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [ADDR_W-1:0] wa, a1, a2;
        logic [XLEN-1:0]   wd;
        logic              we;

        model_ready = 1'b0;
        for (int i = 0; i < NREG; i++) model_mem[i] = '0;
        bus.rs1_a = 0; bus.rs2_a = 0; bus.rd_a = 0; bus.rd_d = 0; bus.rd_we = 0;

        // Power-on reset held 3 cycles, then the full clear.
        apply_reset(3);
        run_clear();

        for (int i = 1; i < NREG; i++) cycle(1'b0, '0, '0, ADDR_W'(i), ADDR_W'(i), 1'b1);

        // Directed writes and reads.
        cycle(1'b1, 5,  32'h0000_000A, 0, 0, 1'b0);
        cycle(1'b1, 31, 32'hFFFF_FFF0, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 5, 31, 1'b0);
        chk("x5 on rs1", bus.rs1_d, 32'h0000_000A);
        chk("x31 on rs2", bus.rs2_d, 32'hFFFF_FFF0);
        cycle(1'b0, 0, 0, 5, 5, 1'b0);
        chk("x5 on both rs1", bus.rs1_d, 32'h0000_000A);
        chk("x5 on both rs2", bus.rs2_d, 32'h0000_000A);
        cycle(1'b1, 0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 0, 0, 1'b0);
        chk("x0 rs1", bus.rs1_d, 32'd0);
        chk("x0 rs2", bus.rs2_d, 32'd0);

        // Same-cycle write and read of x7.
        cycle(1'b1, 7, 32'd4, 0, 0, 1'b0);
        bus.rd_we = 1'b1; bus.rd_a = 7; bus.rd_d = 32'hFFFF_FFFC; bus.rs2_a = 7;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("x7 same-cycle", bus.rs2_d, 32'hFFFF_FFFC);
`else
        chk("x7 same-cycle", bus.rs2_d, 32'h0000_0004);
`endif
        tick();
        model_mem[7] = 32'hFFFF_FFFC;
        bus.rd_we = 1'b0;
        #1;
        chk("x7 after edge", bus.rs2_d, 32'hFFFF_FFFC);

        // Randomized traffic, read addresses often colliding with the write address.
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = ADDR_W'($urandom_range(0, NREG - 1));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, NREG - 1));
            a2 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, NREG - 1));
            cycle(we, wa, wd, a1, a2, 1'b1);
        end

        // Reset in RUN, then a reset aborting a clear partway through.
        cycle(1'b1, 9, 32'd3, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 9, 9, 1'b1);
        apply_reset(1);
        repeat (10) tick();
        apply_reset(1);
        run_clear();
        cycle(1'b0, 0, 0, 9, 5, 1'b0);
        chk("x9 cleared", bus.rs1_d, 32'd0);
        chk("x5 cleared", bus.rs2_d, 32'd0);

        for (int n = 0; n < 40; n++) begin
            cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NREG - 1)), $urandom,
                  ADDR_W'($urandom_range(0, NREG - 1)), ADDR_W'($urandom_range(0, NREG - 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/reg_file.md
# reg_file

Integer register file for the core: 32 × XLEN registers with two asynchronous read ports and one synchronous write port. `rs2_d` feeds the ALU second-operand mux and `rs1_d` feeds the ALU first operand. Write-back drives the write port. The array has no per-flop reset; a post-reset sequencer clears x1..x31 one register per cycle and holds `ready` low until the clear completes.

## Interface
- `XLEN`, default 32: data width of each register.
- `NREG`, default 32: number of registers; must equal `2**ADDR_W`.
- `ADDR_W`, default 5: register address width.

- `clk`  in  1: clock, rising-edge active.
- `rst`  in  1: asynchronous, active-low reset.
- `rs1_a`  in  ADDR_W: read port 1 address.
- `rs2_a`  in  ADDR_W: read port 2 address.
- `rs1_d`  out  XLEN: read port 1 data, combinational.
- `rs2_d`  out  XLEN: read port 2 data, combinational; drives the ALU second-operand mux.
- `rd_a`  in  ADDR_W: write address.
- `rd_d`  in  XLEN: write data.
- `rd_we`  in  1: write enable.
- `ready`  out  1: high when the file is usable; low during reset and clear.

## Operation
- The FSM has two states, CLEAR and RUN.
- Reset (`rst` low):
  - State goes to CLEAR and the clear counter to 1, immediately (asynchronously).
  - `ready` = 0.
  - `rs1_d` = `rs2_d` = 0.
  - Array contents are not reset.
- CLEAR:
  - Each rising edge writes 0 to the register at the counter address, then increments the counter.
  - On the edge that writes register `NREG-1`, the FSM moves to RUN.
- CLEAR, while active:
  - `ready` = 0.
  - `rs1_d` and `rs2_d` are forced to 0.
  - `rd_we` is ignored; no user write takes effect.
- RUN:
  - `ready` = 1.
  - `rsN_d` = array[`rsN_a`], or 0 when `rsN_a` == 0.
  - On a rising edge with `rd_we` = 1 and `rd_a` != 0, array[`rd_a`] <= `rd_d`.
- x0:
  - Reads always return 0.
  - Writes to x0 are discarded, in every state.
- Both read ports can address the same register and then return identical data.
- Reset asserted mid-CLEAR or in RUN:
  - The FSM aborts to CLEAR and the counter returns to 1.
  - The full 31-register clear restarts after `rst` deasserts.
  - Any partially cleared or written contents are overwritten by the clear.
- The clear writes 0 through the same write path as user writes. The array needs only one write port.

## Timing
- Read latency is 0 cycles: outputs follow addresses combinationally.
- Write latency is 1 edge. Without bypass, the new value appears on a read port after the rising edge that performs the write.
- Clear duration is `NREG-1` = 31 rising edges after `rst` deasserts.
  - Edge k (1..31) clears register k.
  - `ready` rises right after edge 31.
  - The first user write is accepted on edge 32.
- `rd_we` asserted while `ready` = 0 is dropped silently. Upstream stalls on `ready`; there is no backpressure beyond `ready`.
- `ready` and FSM state are registered. The only asynchronous paths into them are from `rst`.

## Configuration
- Macro: `REG_FILE_BYPASS_EN`.
- Defined: write-through bypass.
  - In RUN, if `rd_we` = 1, `rd_a` != 0 and `rsN_a` == `rd_a`, then `rsN_d` = `rd_d` in the same cycle.
  - Each read port bypasses independently.
  - No bypass occurs during CLEAR, and no bypass occurs for x0.
- Undefined: no bypass. A same-cycle read of the register being written returns the old contents; the new value is visible after the edge.

## Test plan
- Reset then clear:
  - Stimulus: hold `rst` = 0 for 3 cycles, then release.
  - Required: `ready` = 0 through edge 31 and 1 after it.
  - Then read x1..x31 on both ports: all return 0x00000000.
- Write/read:
  - Stimulus: in RUN, write x5 = 0x0000000A and x31 = 0xFFFFFFF0; set `rs1_a` = 5, `rs2_a` = 31.
  - Required: `rs1_d` = 0x0000000A, `rs2_d` = 0xFFFFFFF0.
  - Stimulus: set `rs1_a` = `rs2_a` = 5. Required: both ports read 0x0000000A.
- x0:
  - Stimulus: write x0 = 0xDEADBEEF; read x0 on both ports.
  - Required: both ports return 0.
- Writes during CLEAR:
  - Stimulus: pulse `rd_we` with `rd_a` = 3, `rd_d` = 0x12345678 on edges 5..10 after reset.
  - Required: after `ready` rises, x3 = 0.
- Same-cycle write and read:
  - Stimulus: drive `rd_we` = 1, `rd_a` = 7, `rd_d` = 0xFFFFFFFC with `rs2_a` = 7; x7 previously held 4.
  - Required before the edge: `rs2_d` = 0xFFFFFFFC with `REG_FILE_BYPASS_EN` defined, 0x00000004 without it.
  - Required after the edge: 0xFFFFFFFC in both builds.
- Reset mid-operation:
  - Stimulus: write x9 = 3, then assert `rst` for 1 cycle.
  - Required: `ready` drops immediately and stays low for 31 edges after release.
  - Then x9 reads 0.
